rega_sequenciador: RTL and testbench

- Irrigation-cycle controller for the watering datapath.
- Accepts a watering request, checks the tank level and soil moisture, then opens the selected valve for a timed countdown. The countdown runs from WATER_TIME to 0, paced by an external 1 Hz Tick.
- After watering it runs a short settling countdown before accepting a new request.
- Sits between the sensor inputs / user button and the valve drivers; exports the live count for the 7-segment display.

---
 rtl/rega_sequenciador.sv | 121 ++++++++++++
 tb/tb_rega_sequenciador.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rega_sequenciador.sv
// Irrigation-cycle controller: request check, timed watering, settling countdown, alarm.
// Optional macro REGA_RETRY_EN: up to two extra watering phases when soil is still dry after settling.
module rega_sequenciador #(
   parameter int COUNT_W       = 3,
   parameter int WATER_TIME    = 5,
   parameter int COOLDOWN_TIME = 3
) (
   input  logic               Clk,
   input  logic               Reset,
   input  logic               Tick,
   input  logic               Start,
   input  logic               Umidade,
   input  logic               NivelBaixo,
   input  logic               Modo,
   output logic               ValvGot,
   output logic               ValvAsp,
   output logic [COUNT_W-1:0] Contagem,
   output logic               Ocupado,
   output logic               Alarme,
   output logic               Fim
);

   localparam logic [COUNT_W-1:0] WT = COUNT_W'(WATER_TIME);
   localparam logic [COUNT_W-1:0] CT = COUNT_W'(COOLDOWN_TIME);

   typedef enum logic [1:0] {IDLE, WATER, COOL, ALARM} state_t;

   state_t state;
   logic   mode;
   logic   retry_go;

`ifdef REGA_RETRY_EN
   logic [1:0] retry;
   assign retry_go = !Umidade && (retry < 2'd2);
`else
   assign retry_go = 1'b0;
`endif

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state    <= IDLE;
         mode     <= 1'b0;
         ValvGot  <= 1'b0;
         ValvAsp  <= 1'b0;
         Contagem <= '0;
         Ocupado  <= 1'b0;
         Alarme   <= 1'b0;
         Fim      <= 1'b0;
`ifdef REGA_RETRY_EN
         retry    <= 2'd0;
`endif
      end else begin
         Fim <= 1'b0;
         case (state)
            IDLE: begin
`ifdef REGA_RETRY_EN
               retry <= 2'd0;
`endif
               if (Start && NivelBaixo) begin
                  state    <= ALARM;
                  Ocupado  <= 1'b1;
                  Alarme   <= 1'b1;
                  Contagem <= '0;
               end else if (Start && !Umidade) begin
                  state    <= WATER;
                  Ocupado  <= 1'b1;
                  Contagem <= WT;
                  mode     <= Modo;
                  ValvGot  <= ~Modo;
                  ValvAsp  <= Modo;
               end
            end
            WATER: begin
               if (NivelBaixo) begin
                  state    <= ALARM;
                  Alarme   <= 1'b1;
                  Contagem <= '0;
                  ValvGot  <= 1'b0;
                  ValvAsp  <= 1'b0;
               end else if (Umidade || (Tick && Contagem == '0)) begin
                  state    <= COOL;
                  Contagem <= CT;
                  ValvGot  <= 1'b0;
                  ValvAsp  <= 1'b0;
               end else if (Tick) begin
                  Contagem <= Contagem - 1'b1;
               end
            end
            COOL: begin
               if (Tick) begin
                  if (Contagem != '0) begin
                     Contagem <= Contagem - 1'b1;
                  end else if (retry_go) begin
                     // Soil still dry: water again with the mode latched at acceptance
                     state    <= WATER;
                     Contagem <= WT;
                     ValvGot  <= ~mode;
                     ValvAsp  <= mode;
`ifdef REGA_RETRY_EN
                     retry    <= retry + 2'd1;
`endif
                  end else begin
                     state   <= IDLE;
                     Ocupado <= 1'b0;
                     Fim     <= 1'b1;
                  end
               end
            end
            ALARM: begin
               if (!NivelBaixo && !Start) begin
                  state   <= IDLE;
                  Ocupado <= 1'b0;
                  Alarme  <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rega_sequenciador.sv
// Bench for rega_sequenciador: directed scenarios plus randomized run against a phase-level model.
module tb_rega_sequenciador;

   localparam int COUNT_W = 3;
   localparam int WT      = 5;
   localparam int CT      = 3;
`ifdef REGA_RETRY_EN
   localparam bit RETRY = 1'b1;
`else
   localparam bit RETRY = 1'b0;
`endif

   localparam int P_IDLE = 0, P_WATER = 1, P_COOL = 2, P_ALARM = 3;

   logic               Clk = 1'b0;
   logic               Reset, Tick, Start, Umidade, NivelBaixo, Modo;
   logic               ValvGot, ValvAsp, Ocupado, Alarme, Fim;
   logic [COUNT_W-1:0] Contagem;

   int errors = 0;
   int checks = 0;

   // reference model: phase, remaining count, latched mode, retries, completion pulse
   int m_ph = P_IDLE, m_cnt = 0, m_retry = 0;
   bit m_mode = 1'b0, m_fim = 1'b0;

   rega_sequenciador #(.COUNT_W(COUNT_W), .WATER_TIME(WT), .COOLDOWN_TIME(CT)) dut (
      .Clk(Clk), .Reset(Reset), .Tick(Tick), .Start(Start), .Umidade(Umidade),
      .NivelBaixo(NivelBaixo), .Modo(Modo), .ValvGot(ValvGot), .ValvAsp(ValvAsp),
      .Contagem(Contagem), .Ocupado(Ocupado), .Alarme(Alarme), .Fim(Fim)
   );

   always #5 Clk = ~Clk;

   task automatic model_edge(input bit r, t, s, u, n, m);
      m_fim = 1'b0;
      if (r) begin
         m_ph = P_IDLE; m_cnt = 0; m_mode = 1'b0; m_retry = 0;
         return;
      end
      case (m_ph)
         P_IDLE: begin
            m_retry = 0;
            if (s && n) begin m_ph = P_ALARM; m_cnt = 0; end
            else if (s && !u) begin m_ph = P_WATER; m_cnt = WT; m_mode = m; end
         end
         P_WATER: begin
            if (n) begin m_ph = P_ALARM; m_cnt = 0; end
            else if (u || (t && m_cnt == 0)) begin m_ph = P_COOL; m_cnt = CT; end
            else if (t) m_cnt = m_cnt - 1;
         end
         P_COOL: begin
            if (t) begin
               if (m_cnt > 0) m_cnt = m_cnt - 1;
               else if (RETRY && !u && m_retry < 2) begin
                  m_ph = P_WATER; m_cnt = WT; m_retry = m_retry + 1;
               end else begin
                  m_ph = P_IDLE; m_fim = 1'b1;
               end
            end
         end
         default: if (!n && !s) m_ph = P_IDLE;
      endcase
   endtask

   // drive one cycle of inputs, advance the model, then settle for sampling
   task automatic step(input bit r, t, s, u, n, m);
      Reset = r; Tick = t; Start = s; Umidade = u; NivelBaixo = n; Modo = m;
      @(posedge Clk);
      model_edge(r, t, s, u, n, m);
      #1;
   endtask

   task automatic test_reset();
      step(1, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0);
      checks++;
      if ({ValvGot, ValvAsp, Ocupado, Alarme, Fim, Contagem} !== 8'b0) begin
         errors++; $display("FAIL reset_initial: got %b expected 0", {ValvGot, ValvAsp, Ocupado, Alarme, Fim, Contagem});
      end
      step(0, 0, 1, 0, 0, 0);
      step(0, 1, 0, 0, 0, 0);
      step(0, 1, 0, 0, 0, 0);
      checks++;
      if ({ValvGot, Contagem} !== {1'b1, 3'd3}) begin
         errors++; $display("FAIL reset_pre_water: got %b expected %b", {ValvGot, Contagem}, {1'b1, 3'd3});
      end
      step(1, 1, 1, 0, 0, 0);
      step(1, 0, 1, 0, 0, 0);
      checks++;
      if ({ValvGot, ValvAsp, Ocupado, Alarme, Fim, Contagem} !== 8'b0) begin
         errors++; $display("FAIL reset_mid_water: got %b expected 0", {ValvGot, ValvAsp, Ocupado, Alarme, Fim, Contagem});
      end
   endtask

   task automatic test_drip_cycle();
      step(0, 0, 1, 0, 0, 0);
      checks++;
      if ({ValvGot, ValvAsp, Ocupado, Contagem} !== {3'b101, 3'd5}) begin
         errors++; $display("FAIL drip_accept: got %b expected %b", {ValvGot, ValvAsp, Ocupado, Contagem}, {3'b101, 3'd5});
      end
      for (int i = 1; i <= 5; i++) begin
         step(0, 1, 0, 0, 0, 0);
         checks++;
         if ({ValvGot, Contagem} !== {1'b1, 3'(5 - i)}) begin
            errors++; $display("FAIL drip_count: got %b expected %b", {ValvGot, Contagem}, {1'b1, 3'(5 - i)});
         end
      end
      step(0, 1, 0, 0, 0, 0);
      checks++;
      if ({ValvGot, ValvAsp, Ocupado, Contagem} !== {3'b001, 3'd3}) begin
         errors++; $display("FAIL drip_to_cool: got %b expected %b", {ValvGot, ValvAsp, Ocupado, Contagem}, {3'b001, 3'd3});
      end
      for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0, 0);
      checks++;
      if ({Fim, Ocupado} !== 2'b01) begin
         errors++; $display("FAIL drip_early_fim: got %b expected 01", {Fim, Ocupado});
      end
      step(0, 1, 0, 1, 0, 0);
      checks++;
      if ({Fim, Ocupado, Contagem} !== 5'b10000) begin
         errors++; $display("FAIL drip_fim: got %b expected 10000", {Fim, Ocupado, Contagem});
      end
      step(0, 0, 0, 0, 0, 0);
      checks++;
      if (Fim !== 1'b0) begin
         errors++; $display("FAIL drip_fim_width: got %b expected 0", Fim);
      end
   endtask

   task automatic test_mode_latch();
      step(0, 0, 1, 0, 0, 1);
      for (int i = 0; i < 5; i++) begin
         checks++;
         if ({ValvGot, ValvAsp} !== 2'b01) begin
            errors++; $display("FAIL mode_latch: got %b expected 01", {ValvGot, ValvAsp});
         end
         step(0, 1, 0, 0, 0, i[0]);
      end
      step(0, 1, 0, 0, 0, 0);
      checks++;
      if ({ValvGot, ValvAsp, Contagem} !== {2'b00, 3'd3}) begin
         errors++; $display("FAIL mode_cool: got %b expected %b", {ValvGot, ValvAsp, Contagem}, {2'b00, 3'd3});
      end
      for (int i = 0; i < 4; i++) step(0, 1, 0, 1, 0, 1);
      checks++;
      if (Fim !== 1'b1) begin
         errors++; $display("FAIL mode_fim: got %b expected 1", Fim);
      end
   endtask

   task automatic test_alarm();
      step(0, 0, 1, 0, 0, 0);
      step(0, 1, 0, 0, 0, 0);
      step(0, 1, 0, 0, 0, 0);
      step(0, 1, 0, 1, 1, 0);
      checks++;
      if ({ValvGot, ValvAsp, Ocupado, Alarme, Contagem} !== {4'b0011, 3'd0}) begin
         errors++; $display("FAIL alarm_enter: got %b expected 0011000", {ValvGot, ValvAsp, Ocupado, Alarme, Contagem});
      end
      step(0, 0, 1, 0, 0, 0);
      checks++;
      if (Alarme !== 1'b1) begin
         errors++; $display("FAIL alarm_hold_start: got %b expected 1", Alarme);
      end
      step(0, 0, 0, 0, 0, 0);
      checks++;
      if ({Ocupado, Alarme, Fim} !== 3'b000) begin
         errors++; $display("FAIL alarm_exit: got %b expected 000", {Ocupado, Alarme, Fim});
      end
   endtask

   task automatic test_early_stop();
      step(0, 0, 1, 0, 0, 0);
      for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0, 0);
      step(0, 0, 0, 1, 0, 0);
      checks++;
      if ({ValvGot, Ocupado, Contagem} !== {2'b01, 3'd3}) begin
         errors++; $display("FAIL early_stop: got %b expected %b", {ValvGot, Ocupado, Contagem}, {2'b01, 3'd3});
      end
      for (int i = 0; i < 4; i++) step(0, 1, 0, 1, 0, 0);
      checks++;
      if (Fim !== 1'b1) begin
         errors++; $display("FAIL early_fim: got %b expected 1", Fim);
      end
      step(0, 0, 1, 1, 0, 0);
      step(0, 0, 1, 1, 0, 0);
      checks++;
      if ({Ocupado, ValvGot, ValvAsp, Fim} !== 4'b0000) begin
         errors++; $display("FAIL wet_request: got %b expected 0000", {Ocupado, ValvGot, ValvAsp, Fim});
      end
   endtask

   task automatic test_retry();
      int vons = 0, fims = 0;
      step(1, 0, 0, 0, 0, 0);
      step(0, 0, 1, 0, 0, 1);
      for (int i = 0; i < 120; i++) begin
         if (i[0] && (ValvGot || ValvAsp)) vons++;
         step(0, i[0], 0, 0, 0, 0);
         if (Fim) fims++;
      end
      checks++;
      if (vons !== (RETRY ? 18 : 6)) begin
         errors++; $display("FAIL retry_valve_ticks: got %0d expected %0d", vons, RETRY ? 18 : 6);
      end
      checks++;
      if ({fims, Ocupado} !== {32'd1, 1'b0}) begin
         errors++; $display("FAIL retry_fim: got fims=%0d busy=%b expected fims=1 busy=0", fims, Ocupado);
      end
   endtask

   task automatic test_random();
      step(1, 0, 0, 0, 0, 0);
      for (int i = 0; i < 600; i++) begin
         step($urandom_range(99) == 0, $urandom_range(2) == 0, $urandom_range(3) == 0,
              $urandom_range(7) == 0, $urandom_range(11) == 0, 1'($urandom));
         checks++;
         if ({ValvGot, ValvAsp, Ocupado, Alarme, Fim, Contagem} !==
             {m_ph == P_WATER && !m_mode, m_ph == P_WATER && m_mode, m_ph != P_IDLE,
              m_ph == P_ALARM, m_fim, 3'(m_cnt)}) begin
            errors++;
            $display("FAIL random_cycle%0d: got got/asp/busy/alm/fim/cnt=%b model phase=%0d cnt=%0d mode=%b fim=%b",
                     i, {ValvGot, ValvAsp, Ocupado, Alarme, Fim, Contagem}, m_ph, m_cnt, m_mode, m_fim);
         end
         checks++;
         if (ValvGot && ValvAsp) begin
            errors++; $display("FAIL random_exclusive: got both valves=1 expected at most one");
         end
      end
   endtask

   initial begin
      test_reset();
      test_drip_cycle();
      test_mode_latch();
      test_alarm();
      test_early_stop();
      test_retry();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
